// File: rtl/bram_dump_reader.sv
// Walks a word range of a bram32 instance through its debug read port and
// streams each word out on valid/ready with its byte address and a last flag.
module bram_dump_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic                  o_m_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ADDR_WIDTH-1:0] r_m_addr;
  logic                  r_m_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_addr    <= '0;
      r_m_last    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur_addr  <= {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
            r_remaining <= i_word_count;
            r_busy      <= 1'b1;
            if (i_word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          // Debug port is combinational, so the word for r_cur_addr is valid now.
          r_m_data  <= i_dbg_data;
          r_m_addr  <= r_cur_addr;
          r_m_last  <= (r_remaining == ONE);
          r_m_valid <= 1'b1;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            if (r_remaining == ONE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cur_addr  <= r_cur_addr + STEP;
              r_remaining <= r_remaining - ONE;
              r_state     <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_dbg_addr = r_cur_addr;
  assign o_m_valid  = r_m_valid;
  assign o_m_data   = r_m_data;
  assign o_m_addr   = r_m_addr;
  assign o_m_last   = r_m_last;

endmodule

// File: doc/bram_dump_reader.md
# bram_dump_reader

Read-side counterpart to the data/instruction BRAM write-port loader. On a `start` command it walks a contiguous word range of a `bram32` instance through the BRAM debug read port (`debug_addr`/`debug_data`) and streams each word out on a valid/ready interface, tagged with its byte address and a last-beat flag. It sits beside the data BRAM, feeding a host link or result checker, and does not disturb the CPU's read/write ports.

## Interface
- `ADDR_WIDTH`, 10, byte-address width of the BRAM debug port.
- `DATA_WIDTH`, 32, word width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launches a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated as 0).
- `word_count`  in  ADDR_WIDTH  number of words to dump; 0 is legal.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a dump completes.
- `dbg_addr`  out  ADDR_WIDTH  drives the BRAM `debug_addr`.
- `dbg_data`  in  DATA_WIDTH  from the BRAM `debug_data`; combinational read of `dbg_addr`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DATA_WIDTH  dumped word.
- `m_addr`  out  ADDR_WIDTH  byte address of `m_data`.
- `m_last`  out  1  high with the final word of the dump.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE: when `start`=1, latch `cur_addr`={base_addr[9:2],2'b00} and `remaining`=`word_count`. If `word_count`=0, go to DONE; otherwise go to READ. `start` in any other state is ignored, with no queuing.
- READ: `dbg_addr`=`cur_addr`. At the edge, capture `dbg_data` into `m_data`, `cur_addr` into `m_addr`, and (`remaining`==1) into `m_last`, then go to SEND.
- SEND: `m_valid`=1. On an edge with `m_ready`=1:
  - if `remaining`==1, go to DONE;
  - otherwise `cur_addr`+=4, `remaining`-=1, and go to READ.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Passing 0x3FC wraps to 0x000. A `word_count` above 256 re-reads wrapped locations and emits them normally.
- `word_count` and `base_addr` are used only at the start edge; later changes have no effect.
- The block never writes the BRAM.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `m_addr`=0, `dbg_addr`=0.
- Reset mid-dump returns to IDLE at that edge. `m_valid` is low in the following cycle, and no `done` pulse is produced.
- Edge E0: `start` is sampled in IDLE, and `busy` rises after E0.
- Edge E1: the first word is captured, and `m_valid` is high after E1.
- Per-word throughput is at best 2 cycles (READ + SEND). Each extra stall cycle with `m_ready`=0 adds one cycle.
- While `m_valid`=1 and `m_ready`=0, `m_data`, `m_addr` and `m_last` hold stable and `m_valid` stays high.
- `m_valid` is never withdrawn without a handshake, except by `rst`.
- `m_ready` has no effect outside SEND.
- `done` is high in the cycle after the final handshake edge. `busy` drops in the cycle after `done`.
- `word_count`=0: `done` is high in the cycle after E0, and no beat is emitted.
- `dbg_addr` holds `cur_addr` outside READ as well. The BRAM debug port must return data combinationally within one cycle.

## Test plan
- BRAM words 0x0/0x4/0x8 = 00000001/00000003/00000005; base 0x0, count 3, `m_ready` tied 1 -> three beats with those data, `m_addr` 0x0/0x4/0x8, `m_last` only on the third; `done` once; 2 cycles per beat.
- Same setup with `m_ready` toggling 0,0,1 per beat -> `m_data`/`m_addr`/`m_last` stable through the stalls, no beat dropped or duplicated, same three words in order.
- base 0x3F8, count 4, mem[0x3F8]=AAAA0000, mem[0x3FC]=BBBB0000, mem[0x0]=00000001, mem[0x4]=00000003 -> `m_addr` sequence 0x3F8, 0x3FC, 0x000, 0x004 with matching data.
- count 0 with `start` pulsed -> no `m_valid`, `done` high one cycle after the start edge, `busy` high for exactly that cycle.
- `start` re-pulsed with base 0x100 during a 3-word dump at 0x0, then `rst` asserted during the 2nd SEND -> the re-pulse is ignored (addresses 0x0, 0x4 only); after `rst`, `m_valid`=0, `busy`=0, all outputs at reset values, no `done`.
- base_addr=0x00E, count 1, mem[0xC]=00000005 -> one beat, `m_addr`=0x00C, `m_data`=00000005, `m_last`=1.
